// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcode map,
// instruction classes, ALU operation codes and the step/state encoding.
package cpu_ctrl_pkg;

    localparam int OPCODE_W   = 5;
    localparam int ALU_CTRL_W = 4;

    // Opcode map; gaps (10, 20-23, 28-31) are undefined and execute as NOP
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_BR   = 5'd19;
    localparam logic [OPCODE_W-1:0] OP_MFHI = 5'd24;
    localparam logic [OPCODE_W-1:0] OP_MFLO = 5'd25;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'd27;

    typedef enum logic [3:0] {
        CLS_ALU_RR, CLS_ALU_RI, CLS_UNARY, CLS_MULDIV,
        CLS_LD, CLS_LDI, CLS_ST, CLS_BR,
        CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT
    } instr_class_e;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,  ALU_OR  = 4'd3,
        ALU_SHR = 4'd4, ALU_SHL = 4'd5, ALU_ROR = 4'd6,  ALU_ROL = 4'd7,
        ALU_MUL = 4'd8, ALU_DIV = 4'd9, ALU_NEG = 4'd10, ALU_NOT = 4'd11
    } alu_op_e;

    // T0..T7 share the low three bits with the step number; HALTED sits above
    typedef enum logic [3:0] {
        ST_T0 = 4'd0, ST_T1 = 4'd1, ST_T2 = 4'd2, ST_T3 = 4'd3,
        ST_T4 = 4'd4, ST_T5 = 4'd5, ST_T6 = 4'd6, ST_T7 = 4'd7,
        ST_HALTED = 4'd8
    } step_e;

    function automatic step_e lastStep(input instr_class_e cls);
        case (cls)
            CLS_ALU_RR, CLS_ALU_RI, CLS_LDI: lastStep = ST_T5;
            CLS_UNARY:                       lastStep = ST_T4;
            CLS_MULDIV, CLS_BR:              lastStep = ST_T6;
            CLS_LD, CLS_ST:                  lastStep = ST_T7;
            default:                         lastStep = ST_T3;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode decoder: maps the IR opcode field onto an
// instruction class and the ALU operation that class should request.
module instr_class_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [OPCODE_W-1:0]   opcode_i,
    output logic [3:0]            class_o,
    output logic [ALU_CTRL_W-1:0] alu_op_o
);

    instr_class_e cls;
    alu_op_e      op;

    always_comb begin
        cls = CLS_NOP;
        op  = ALU_ADD;
        case (opcode_i)
            OP_ADD:  begin cls = CLS_ALU_RR; op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_ALU_RR; op = ALU_SUB; end
            OP_AND:  begin cls = CLS_ALU_RR; op = ALU_AND; end
            OP_OR:   begin cls = CLS_ALU_RR; op = ALU_OR;  end
            OP_SHR:  begin cls = CLS_ALU_RR; op = ALU_SHR; end
            OP_SHL:  begin cls = CLS_ALU_RR; op = ALU_SHL; end
            OP_ROR:  begin cls = CLS_ALU_RR; op = ALU_ROR; end
            OP_ROL:  begin cls = CLS_ALU_RR; op = ALU_ROL; end
            OP_ADDI: begin cls = CLS_ALU_RI; op = ALU_ADD; end
            OP_ANDI: begin cls = CLS_ALU_RI; op = ALU_AND; end
            OP_ORI:  begin cls = CLS_ALU_RI; op = ALU_OR;  end
            OP_NEG:  begin cls = CLS_UNARY;  op = ALU_NEG; end
            OP_NOT:  begin cls = CLS_UNARY;  op = ALU_NOT; end
            OP_MUL:  begin cls = CLS_MULDIV; op = ALU_MUL; end
            OP_DIV:  begin cls = CLS_MULDIV; op = ALU_DIV; end
            OP_LD:   cls = CLS_LD;
            OP_LDI:  cls = CLS_LDI;
            OP_ST:   cls = CLS_ST;
            OP_BR:   cls = CLS_BR;
            OP_MFHI: cls = CLS_MFHI;
            OP_MFLO: cls = CLS_MFLO;
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end

    assign class_o  = cls;
    assign alu_op_o = op;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus datapath: common fetch
// in T0-T2, then class-specific execute steps, with a sticky halted state.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW   = 5,
    parameter int CTRLW = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic [OPW-1:0]   Opcode,
    input  logic             CON_FF,
    input  logic             Stop,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             Read,
    output logic             Write,
    output logic             IRin,
    output logic             Yin,
    output logic             CONin,
    output logic             Zhighin,
    output logic             Zlowin,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             HIin,
    output logic             HIout,
    output logic             LOin,
    output logic             LOout,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic [CTRLW-1:0] ctrl,
    output logic             Run
);

    step_e           state_q, state_d;
    logic [3:0]      decClass;
    logic [3:0]      decAlu;
    instr_class_e    cls;
    alu_op_e         clsAlu;
    alu_op_e         aluSel;
    step_e           endStep;

    instr_class_decode u_decode (
        .opcode_i (Opcode),
        .class_o  (decClass),
        .alu_op_o (decAlu)
    );

    assign cls     = instr_class_e'(decClass);
    assign clsAlu  = alu_op_e'(decAlu);
    assign endStep = lastStep(cls);

    always_ff @(posedge Clock) begin
        if (Clear) state_q <= ST_T0;
        else       state_q <= state_d;
    end

    // Stop is only honoured on the final step, so an instruction always completes
    always_comb begin
        state_d = ST_T0;
        case (state_q)
            ST_T0:     state_d = ST_T1;
            ST_T1:     state_d = ST_T2;
            ST_T2:     state_d = ST_T3;
            ST_HALTED: state_d = ST_HALTED;
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (state_q == endStep)
                    state_d = (Stop || cls == CLS_HALT) ? ST_HALTED : ST_T0;
                else if (state_q < endStep)
                    state_d = step_e'(state_q + 4'd1);
                else
                    state_d = ST_T0;
            end
            default:   state_d = ST_T0;
        endcase
    end

    // Clear masks every strobe so an aborted step never commits a write
    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, CONin,
         Zhighin, Zlowin, Zhighout, Zlowout, HIin, HIout, LOin, LOout,
         Gra, Grb, Grc, Rin, Rout, BAout, Cout} = '0;
        aluSel = ALU_ADD;
        Run    = 1'b1;
        if (!Clear) begin
            case (state_q)
                ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; end
                ST_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
                ST_T3: begin
                    case (cls)
                        CLS_ALU_RR, CLS_ALU_RI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        CLS_UNARY: begin Grb = 1'b1; Rout = 1'b1; Zlowin = 1'b1; aluSel = clsAlu; end
                        CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                        CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                        CLS_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                        CLS_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T4: begin
                    case (cls)
                        CLS_ALU_RR: begin Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; aluSel = clsAlu; end
                        CLS_ALU_RI: begin Cout = 1'b1; Zlowin = 1'b1; aluSel = clsAlu; end
                        CLS_UNARY:  begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_MULDIV: begin
                            Grb = 1'b1; Rout = 1'b1; Zhighin = 1'b1; Zlowin = 1'b1;
                            aluSel = clsAlu;
                        end
                        CLS_LD, CLS_LDI, CLS_ST: begin Cout = 1'b1; Zlowin = 1'b1; end
                        CLS_BR: begin PCout = 1'b1; Yin = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T5: begin
                    case (cls)
                        CLS_ALU_RR, CLS_ALU_RI, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_MULDIV:     begin Zlowout = 1'b1; LOin = 1'b1; end
                        CLS_LD, CLS_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                        CLS_BR:         begin Cout = 1'b1; Zlowin = 1'b1; end
                        default: ;
                    endcase
                end
                ST_T6: begin
                    case (cls)
                        CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
                        CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                        CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                        CLS_BR:     begin Zlowout = 1'b1; PCin = CON_FF; end
                        default: ;
                    endcase
                end
                ST_T7: begin
                    case (cls)
                        CLS_LD: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        CLS_ST: Write = 1'b1;
                        default: ;
                    endcase
                end
                ST_HALTED: Run = 1'b0;
                default: ;
            endcase
        end
    end

    assign ctrl = CTRLW'(aluSel);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed scenarios followed by random instruction
// streams, each cycle compared against a per-instruction strobe table.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    typedef logic [29:0] obsT;

    localparam obsT PCOUT    = 30'd1 << 0;
    localparam obsT PCIN     = 30'd1 << 1;
    localparam obsT INCPC    = 30'd1 << 2;
    localparam obsT MARIN    = 30'd1 << 3;
    localparam obsT MDRIN    = 30'd1 << 4;
    localparam obsT MDROUT   = 30'd1 << 5;
    localparam obsT READ     = 30'd1 << 6;
    localparam obsT WRITE    = 30'd1 << 7;
    localparam obsT IRIN     = 30'd1 << 8;
    localparam obsT YIN      = 30'd1 << 9;
    localparam obsT CONIN    = 30'd1 << 10;
    localparam obsT ZHIGHIN  = 30'd1 << 11;
    localparam obsT ZLOWIN   = 30'd1 << 12;
    localparam obsT ZHIGHOUT = 30'd1 << 13;
    localparam obsT ZLOWOUT  = 30'd1 << 14;
    localparam obsT HIIN     = 30'd1 << 15;
    localparam obsT HIOUT    = 30'd1 << 16;
    localparam obsT LOIN     = 30'd1 << 17;
    localparam obsT LOOUT    = 30'd1 << 18;
    localparam obsT GRA      = 30'd1 << 19;
    localparam obsT GRB      = 30'd1 << 20;
    localparam obsT GRC      = 30'd1 << 21;
    localparam obsT RIN      = 30'd1 << 22;
    localparam obsT ROUT     = 30'd1 << 23;
    localparam obsT BAOUT    = 30'd1 << 24;
    localparam obsT COUT     = 30'd1 << 25;

    logic       Clock, Clear, CON_FF, Stop;
    logic [4:0] Opcode;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin, CONin;
    logic Zhighin, Zlowin, Zhighout, Zlowout, HIin, HIout, LOin, LOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, Run;
    logic [3:0]  ctrl;
    logic [25:0] strobes;

    int  passCount  = 0;
    int  totalCount = 0;
    obsT expQ[$];

    control_sequencer #(.OPW(5), .CTRLW(4)) dut (
        .Clock(Clock), .Clear(Clear), .Opcode(Opcode), .CON_FF(CON_FF), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
        .CONin(CONin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .ctrl(ctrl), .Run(Run)
    );

    assign strobes = {Cout, BAout, Rout, Rin, Grc, Grb, Gra, LOout, LOin, HIout, HIin,
                      Zlowout, Zhighout, Zlowin, Zhighin, CONin, Yin, IRin, Write, Read,
                      MDRout, MDRin, MARin, IncPC, PCin, PCout};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic obsT ctl(input logic [3:0] a);
        return {a, 26'd0};
    endfunction

    // Cycle-by-cycle strobe table for one whole instruction, fetch included
    task automatic buildProgram(input logic [4:0] op, input logic con);
        logic [3:0] a;
        expQ = {};
        expQ.push_back(PCOUT | MARIN | INCPC | ZLOWIN);
        expQ.push_back(ZLOWOUT | PCIN | READ | MDRIN);
        expQ.push_back(MDROUT | IRIN);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                case (op)
                    OP_ADD: a = 0; OP_SUB: a = 1; OP_AND: a = 2; OP_OR: a = 3;
                    OP_SHR: a = 4; OP_SHL: a = 5; OP_ROR: a = 6; default: a = 7;
                endcase
                expQ.push_back(GRB | ROUT | YIN);
                expQ.push_back(GRC | ROUT | ZLOWIN | ctl(a));
                expQ.push_back(ZLOWOUT | GRA | RIN);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                a = (op == OP_ADDI) ? 4'd0 : (op == OP_ANDI) ? 4'd2 : 4'd3;
                expQ.push_back(GRB | ROUT | YIN);
                expQ.push_back(COUT | ZLOWIN | ctl(a));
                expQ.push_back(ZLOWOUT | GRA | RIN);
            end
            OP_NEG, OP_NOT: begin
                a = (op == OP_NEG) ? 4'd10 : 4'd11;
                expQ.push_back(GRB | ROUT | ZLOWIN | ctl(a));
                expQ.push_back(ZLOWOUT | GRA | RIN);
            end
            OP_MUL, OP_DIV: begin
                a = (op == OP_MUL) ? 4'd8 : 4'd9;
                expQ.push_back(GRA | ROUT | YIN);
                expQ.push_back(GRB | ROUT | ZHIGHIN | ZLOWIN | ctl(a));
                expQ.push_back(ZLOWOUT | LOIN);
                expQ.push_back(ZHIGHOUT | HIIN);
            end
            OP_LD, OP_LDI, OP_ST: begin
                expQ.push_back(GRB | BAOUT | YIN);
                expQ.push_back(COUT | ZLOWIN);
                if (op == OP_LDI) expQ.push_back(ZLOWOUT | GRA | RIN);
                else begin
                    expQ.push_back(ZLOWOUT | MARIN);
                    if (op == OP_LD) begin
                        expQ.push_back(READ | MDRIN);
                        expQ.push_back(MDROUT | GRA | RIN);
                    end else begin
                        expQ.push_back(GRA | ROUT | MDRIN);
                        expQ.push_back(WRITE);
                    end
                end
            end
            OP_BR: begin
                expQ.push_back(GRA | ROUT | CONIN);
                expQ.push_back(PCOUT | YIN);
                expQ.push_back(COUT | ZLOWIN);
                expQ.push_back(ZLOWOUT | (con ? PCIN : '0));
            end
            OP_MFHI: expQ.push_back(HIOUT | GRA | RIN);
            OP_MFLO: expQ.push_back(LOOUT | GRA | RIN);
            default: expQ.push_back('0);
        endcase
    endtask

    task automatic checkOutput(input string tag, input obsT expected, input logic expRun);
        obsT observed;
        observed = {ctrl, strobes};
        totalCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s strobes observed=%h expected=%h", tag, observed, expected);
        totalCount++;
        assert (Run === expRun) passCount++;
        else $error("[TB] FAIL %s Run observed=%b expected=%b", tag, Run, expRun);
    endtask

    // Runs one instruction; abortAt picks a cycle to assert Clear, stopMask drives Stop per cycle
    task automatic applyStimulus(input logic [4:0] op, input logic con, input int abortAt,
                                 input logic [7:0] stopMask, input int haltCycles);
        logic toHalt;
        toHalt = 1'b0;
        buildProgram(op, con);
        for (int k = 0; k < expQ.size(); k++) begin
            @(negedge Clock);
            Opcode = op;
            CON_FF = con;
            Stop   = stopMask[k];
            Clear  = (k == abortAt);
            #1;
            if (Clear) begin
                checkOutput($sformatf("op%0d T%0d cleared", op, k), '0, 1'b1);
                return;
            end
            checkOutput($sformatf("op%0d T%0d", op, k), expQ[k], 1'b1);
            if (k == expQ.size() - 1) toHalt = Stop || (op == OP_HALT);
        end
        if (toHalt) begin
            for (int n = 0; n < haltCycles; n++) begin
                @(negedge Clock);
                Opcode = 5'($urandom);
                CON_FF = 1'($urandom);
                Stop   = 1'($urandom);
                Clear  = 1'b0;
                #1;
                checkOutput($sformatf("halted after op%0d cyc%0d", op, n), '0, 1'b0);
            end
            @(negedge Clock);
            Clear = 1'b1;
            Stop  = 1'b0;
            #1;
            checkOutput("clear from halted", '0, 1'b1);
        end
    endtask

    initial begin
        logic [4:0] op;
        logic       con;
        int         abortAt;
        logic [7:0] stopMask;

        Clear = 1'b1; Opcode = 5'd0; CON_FF = 1'b0; Stop = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            #1;
            checkOutput("reset", '0, 1'b1);
        end

        $display("[TB] directed scenarios");
        applyStimulus(OP_ADD, 1'b0, -1, 8'h00, 0);
        applyStimulus(OP_LD,  1'b0, -1, 8'h00, 0);
        applyStimulus(OP_ST,  1'b0, -1, 8'h00, 0);
        applyStimulus(OP_BR,  1'b0, -1, 8'h00, 0);
        applyStimulus(OP_BR,  1'b1, -1, 8'h00, 0);
        applyStimulus(OP_MUL, 1'b0,  5, 8'h00, 0);
        applyStimulus(OP_SUB, 1'b0, -1, 8'h00, 0);
        applyStimulus(OP_ADD, 1'b0, -1, 8'h30, 12);
        applyStimulus(OP_HALT, 1'b0, -1, 8'h00, 10);
        applyStimulus(OP_NOP, 1'b0, -1, 8'h08, 3);
        applyStimulus(OP_DIV, 1'b1, -1, 8'h0F, 0);

        $display("[TB] random instruction stream");
        for (int i = 0; i < 300; i++) begin
            op       = 5'($urandom_range(0, 31));
            con      = 1'($urandom);
            abortAt  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
            stopMask = 8'($urandom) & 8'($urandom) & 8'($urandom);
            applyStimulus(op, con, abortAt, stopMask, int'($urandom_range(2, 6)));
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
